dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL reset on the falling edge of rst_n, independent of clk.
REQ-002 Port list (name, direction, width, meaning), clock and reset first:
 - clk  in  1  rising-edge clock
 - rst_n  in  1  asynchronous active-low reset
 - p0_valid / p1_valid  in  1  request present on port 0 / port 1
 - p0_ready / p1_ready  out  1  request accepted this cycle
 - p0_we / p1_we  in  1  1 = write, 0 = read
 - p0_addr / p1_addr  in  32  word address
 - p0_wdata / p1_wdata  in  32  write data
 - p0_rsp_valid / p1_rsp_valid  out  1  one-cycle response pulse
 - p0_rsp_rdata / p1_rsp_rdata  out  32  read data; 0 for writes and errors
 - p0_rsp_err / p1_rsp_err  out  1  address out of range; qualified by rsp_valid
 - mem_addr  out  32  to data memory address
 - mem_wd  out  32  to data memory write data
 - mem_we  out  1  to data memory write enable
 - mem_rd  in  32  from data memory combinational read data
REQ-003 Parameter: DEPTH, default 64, number of 32-bit words in the attached memory; a valid address satisfies addr < DEPTH.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 IDLE: a port is granted if it is valid and either the other port is not valid or the round-robin pointer favours it; the granted port's ready SHALL be 1 combinationally; all other readys SHALL be 0.
REQ-006 Port valid SHALL NOT depend on ready; a requester SHALL hold valid, we, addr and wdata stable until it is accepted.
REQ-007 On handshake (valid && ready): latch port id, we, addr and wdata; compute err = (addr >= DEPTH); go to ACCESS; flip the pointer to the other port.
REQ-008 ACCESS, one cycle: drive mem_addr/mem_wd from the latched values; mem_we = latched we && !err; capture mem_rd into the response register when (!we && !err), otherwise load 0; go to RESP.
REQ-009 RESP, one cycle: assert rsp_valid only for the latched port, with rsp_rdata/rsp_err from the response register; go to IDLE.
REQ-010 Latency: handshake in cycle T -> memory write at the clk edge that ends T+1 -> rsp_valid high in cycle T+2; throughput is one request per 3 cycles; ready SHALL be 0 in ACCESS and RESP.
REQ-011 mem_we SHALL be 0 in every state except ACCESS; mem_addr/mem_wd SHALL hold their last latched values outside ACCESS.
REQ-012 Simultaneous valid on both ports: the port the pointer favours wins; the loser keeps valid and SHALL be granted on the next IDLE, so no port waits more than one transaction.
REQ-013 rsp_rdata SHALL hold its value after the pulse until the next response to the same port; rsp_err is meaningful only while rsp_valid is 1.
REQ-014 An out-of-range address SHALL never write memory and SHALL return rdata 0 and err 1.

Reset
REQ-015 Reset values: state IDLE, pointer = port 0, all ready/rsp_valid/rsp_err = 0, rsp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wd = 0.
REQ-016 Reset asserted in ACCESS or RESP SHALL drop mem_we immediately and discard the in-flight request with no response; the requester SHALL reissue it.

Verification
REQ-017 p0 write addr 5, data 0xDEADBEEF, then p0 read addr 5 -> mem[5] = 0xDEADBEEF; read rsp_valid 2 cycles after its handshake with rdata 0xDEADBEEF, err 0.
REQ-018 p0 and p1 both valid out of reset (p0 read addr 1, p1 read addr 2) -> p0 granted first, p1 granted on the next IDLE (3 cycles later); two responses in order p0, then p1.
REQ-019 Both ports stream continuously for 8 requests -> grants alternate p0,p1,p0,... and each port receives exactly 4 responses.
REQ-020 p1 write addr 64, data 0x12345678 with DEPTH 64 -> mem_we stays 0, no memory word changes; p1_rsp_err = 1 and rdata = 0.
REQ-021 rst_n pulled low during ACCESS of a write to addr 3 -> mem_we 0 immediately, mem[3] unchanged, no rsp_valid; after release, ready returns in IDLE and the pointer is port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each accepted request takes three cycles: grant, memory access, response pulse.
//   state  | meaning
//   IDLE   | arbitrate, accept at most one request
//   ACCESS | drive memory with the latched request, capture read data
//   RESP   | one-cycle response pulse to the latched port
module dmem_arbiter #(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_valid,
   output logic        p0_ready,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_rsp_valid,
   output logic [31:0] p0_rsp_rdata,
   output logic        p0_rsp_err,
   input  logic        p1_valid,
   output logic        p1_ready,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_rsp_valid,
   output logic [31:0] p1_rsp_rdata,
   output logic        p1_rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        grant0, grant1, hs;
   logic [31:0] sel_addr;
   logic [31:0] resp_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (hs) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ptr_q = 1 favours port 1 when both ports request together
   always_comb begin
      grant0       = 1'b0;
      grant1       = 1'b0;
      mem_we       = 1'b0;
      p0_rsp_valid = 1'b0;
      p1_rsp_valid = 1'b0;
      p0_rsp_err   = 1'b0;
      p1_rsp_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            grant0 = rst_n && p0_valid && (!p1_valid || !ptr_q);
            grant1 = rst_n && p1_valid && (!p0_valid ||  ptr_q);
         end
         S_ACCESS: mem_we = we_q && !err_q;
         S_RESP: begin
            p0_rsp_valid = !port_q;
            p1_rsp_valid =  port_q;
            p0_rsp_err   = !port_q && err_q;
            p1_rsp_err   =  port_q && err_q;
         end
         default: ;
      endcase
   end

   assign hs           = grant0 || grant1;
   assign p0_ready     = grant0;
   assign p1_ready     = grant1;
   assign mem_addr     = addr_q;
   assign mem_wd       = wdata_q;
   assign p0_rsp_rdata = rdata0_q;
   assign p1_rsp_rdata = rdata1_q;
   assign sel_addr     = grant1 ? p1_addr : p0_addr;
   assign resp_word    = (!we_q && !err_q) ? mem_rd : 32'h0;

   always_comb begin
      ptr_d    = ptr_q;
      port_d   = port_q;
      we_d     = we_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      if (hs) begin
         ptr_d   = grant0;
         port_d  = grant1;
         we_d    = grant1 ? p1_we : p0_we;
         addr_d  = sel_addr;
         wdata_d = grant1 ? p1_wdata : p0_wdata;
         err_d   = (sel_addr >= 32'(DEPTH));
      end
      if (state_q == S_ACCESS) begin
         if (port_q) rdata1_d = resp_word;
         else        rdata0_d = resp_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= 1'b0;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata0_q <= 32'h0;
         rdata1_q <= 32'h0;
      end else begin
         ptr_q    <= ptr_d;
         port_q   <= port_d;
         we_q     <= we_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model of arbitration, memory contents and response timing.
module tb_dmem_arbiter;

   localparam int DEPTH = 64;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
   logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
   logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
   logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] envmem [DEPTH];
   logic [31:0] refmem [DEPTH];
   logic        mem_loaded = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   req_t q0[$], q1[$];
   int   hs_port[$], hs_cyc[$];
   int   rsp_cnt [2];

   // transaction-level model state
   int          cyc;
   int          idle_in;
   bit          ptr;
   bit          have_rsp, m_port, m_err;
   int          rsp_due;
   logic [31:0] m_rdata;
   bit          have_wr;
   int          wr_due;
   logic [31:0] wr_addr, wr_data;
   logic [31:0] last_rd [2];

   dmem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
      .p0_rsp_err(p0_rsp_err),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
      .p1_rsp_err(p1_rsp_err),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < DEPTH; i++) envmem[i] <= 32'hC0DE_0000 + 32'(i);
         mem_loaded <= 1'b1;
      end else if (mem_we && mem_addr < 32'(DEPTH)) begin
         envmem[mem_addr[5:0]] <= mem_wd;
      end
   end

   always_comb begin
      mem_rd = 32'h0;
      if (mem_addr < 32'(DEPTH)) mem_rd = envmem[mem_addr[5:0]];
   end

   task automatic chk1(string tag, logic obs, logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      idle_in = 0; ptr = 1'b0; have_rsp = 1'b0; have_wr = 1'b0;
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
   endtask

   task automatic drive();
      p0_valid = (q0.size() != 0);
      p1_valid = (q1.size() != 0);
      if (p0_valid) begin p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata; end
      else begin p0_we = 1'($urandom); p0_addr = $urandom; p0_wdata = $urandom; end
      if (p1_valid) begin p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata; end
      else begin p1_we = 1'($urandom); p1_addr = $urandom; p1_wdata = $urandom; end
   endtask

   task automatic sample();
      int   g;
      bit   e0, e1, ew, err;
      req_t r;
      g = -1;
      if (idle_in == 0) begin
         if (p0_valid && (!p1_valid || !ptr)) g = 0;
         else if (p1_valid) g = 1;
      end
      chk1("p0_ready", p0_ready, g == 0);
      chk1("p1_ready", p1_ready, g == 1);
      e0 = have_rsp && rsp_due == cyc && !m_port;
      e1 = have_rsp && rsp_due == cyc &&  m_port;
      chk1("p0_rsp_valid", p0_rsp_valid, e0);
      chk1("p1_rsp_valid", p1_rsp_valid, e1);
      if (e0) chk1("p0_rsp_err", p0_rsp_err, m_err);
      if (e1) chk1("p1_rsp_err", p1_rsp_err, m_err);
      if (e0 || e1) begin
         last_rd[int'(m_port)] = m_rdata;
         have_rsp = 1'b0;
      end
      chk32("p0_rsp_rdata", p0_rsp_rdata, last_rd[0]);
      chk32("p1_rsp_rdata", p1_rsp_rdata, last_rd[1]);
      if (p0_rsp_valid) rsp_cnt[0]++;
      if (p1_rsp_valid) rsp_cnt[1]++;
      ew = have_wr && wr_due == cyc;
      chk1("mem_we", mem_we, ew);
      if (ew) begin
         chk32("mem_addr", mem_addr, wr_addr);
         chk32("mem_wd", mem_wd, wr_data);
         refmem[wr_addr[5:0]] = wr_data;
         have_wr = 1'b0;
      end
      if (g >= 0) begin
         r = (g == 1) ? q1[0] : q0[0];
         err = (r.addr >= 32'(DEPTH));
         have_rsp = 1'b1; m_port = (g == 1); m_err = err; rsp_due = cyc + 2;
         m_rdata = (r.we || err) ? 32'h0 : refmem[r.addr[5:0]];
         if (r.we && !err) begin
            have_wr = 1'b1; wr_due = cyc + 1; wr_addr = r.addr; wr_data = r.wdata;
         end
         ptr = (g == 0);
         idle_in = 3;
      end
      if (idle_in > 0) idle_in--;
      if (p0_valid && p0_ready) begin void'(q0.pop_front()); hs_port.push_back(0); hs_cyc.push_back(cyc); end
      if (p1_valid && p1_ready) begin void'(q1.pop_front()); hs_port.push_back(1); hs_cyc.push_back(cyc); end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_idle(int budget);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || have_rsp || idle_in != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk1("drain_in_budget", n < budget, 1'b1);
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.we    = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
      case ($urandom_range(0, 9))
         0:       r.addr = 32'($urandom_range(64, 80));
         1:       r.addr = $urandom | 32'h8000_0000;
         default: r.addr = 32'($urandom_range(0, DEPTH - 1));
      endcase
      return r;
   endfunction

   task automatic clear_logs();
      hs_port.delete(); hs_cyc.delete();
      rsp_cnt[0] = 0; rsp_cnt[1] = 0;
   endtask

   initial begin
      logic [31:0] old3;
      for (int i = 0; i < DEPTH; i++) refmem[i] = 32'hC0DE_0000 + 32'(i);
      model_reset();
      clear_logs();
      cyc = 0;

      // reset with both ports requesting: nothing may be granted
      rst_n = 1'b0;
      p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'd7; p0_wdata = 32'h1111_1111;
      p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'd8; p1_wdata = 32'h2222_2222;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_p0_ready", p0_ready, 1'b0);
      chk1("rst_p1_ready", p1_ready, 1'b0);
      chk1("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
      chk1("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
      chk1("rst_p0_rsp_err", p0_rsp_err, 1'b0);
      chk1("rst_p1_rsp_err", p1_rsp_err, 1'b0);
      chk32("rst_p0_rsp_rdata", p0_rsp_rdata, 32'h0);
      chk32("rst_p1_rsp_rdata", p1_rsp_rdata, 32'h0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wd", mem_wd, 32'h0);
      rst_n = 1'b1;

      // both ports valid straight out of reset
      q0.push_back('{1'b0, 32'd1, 32'h0});
      q1.push_back('{1'b0, 32'd2, 32'h0});
      run_idle(50);
      chk32("r18_hs_count", hs_port.size(), 32'd2);
      chk32("r18_first", hs_port[0], 32'd0);
      chk32("r18_second", hs_port[1], 32'd1);
      chk32("r18_spacing", hs_cyc[1] - hs_cyc[0], 32'd3);
      chk32("r18_p0_rdata", p0_rsp_rdata, 32'hC0DE_0001);
      chk32("r18_p1_rdata", p1_rsp_rdata, 32'hC0DE_0002);

      // write then read back on port 0
      clear_logs();
      q0.push_back('{1'b1, 32'd5, 32'hDEAD_BEEF});
      q0.push_back('{1'b0, 32'd5, 32'h0});
      run_idle(50);
      chk32("r17_mem5", envmem[5], 32'hDEAD_BEEF);
      chk32("r17_rdata", p0_rsp_rdata, 32'hDEAD_BEEF);

      // out-of-range write on port 1
      clear_logs();
      q1.push_back('{1'b1, 32'd64, 32'h1234_5678});
      run_idle(50);
      chk32("r20_rdata", p1_rsp_rdata, 32'h0);
      chk32("r20_responses", rsp_cnt[1], 32'd1);
      for (int i = 0; i < DEPTH; i++) chk32("r20_mem_word", envmem[i], refmem[i]);

      // both ports streaming four requests each
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{1'b0, 32'(10 + i), 32'h0});
         q1.push_back('{1'b1, 32'(20 + i), $urandom});
      end
      run_idle(100);
      chk32("r19_hs_count", hs_port.size(), 32'd8);
      for (int i = 1; i < hs_port.size(); i++)
         chk1("r19_alternate", hs_port[i] != hs_port[i-1], 1'b1);
      chk32("r19_p0_rsp", rsp_cnt[0], 32'd4);
      chk32("r19_p1_rsp", rsp_cnt[1], 32'd4);

      // reset during the ACCESS cycle of a write to address 3
      clear_logs();
      old3 = refmem[3];
      q0.push_back('{1'b1, 32'd3, 32'h55AA_55AA});
      cycle();
      chk32("r21_hs", hs_port.size(), 32'd1);
      drive();
      #2;
      chk1("r21_we_before", mem_we, have_wr && wr_due == cyc);
      rst_n = 1'b0;
      #1;
      chk1("r21_we_async", mem_we, 1'b0);
      p0_valid = 1'b1; p1_valid = 1'b1;
      #1;
      chk1("r21_p0_ready_rst", p0_ready, 1'b0);
      chk1("r21_p1_ready_rst", p1_ready, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      chk1("r21_we_held", mem_we, 1'b0);
      chk1("r21_p0_rsp", p0_rsp_valid, 1'b0);
      chk1("r21_p1_rsp", p1_rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc += 3;
      chk32("r21_mem3", envmem[3], old3);
      clear_logs();
      q0.push_back('{1'b0, 32'd3, 32'h0});
      q1.push_back('{1'b0, 32'd4, 32'h0});
      run_idle(50);
      chk32("r21_first_after_rst", hs_port[0], 32'd0);
      chk32("r21_read3", p0_rsp_rdata, old3);
      chk32("r21_rsp_total", rsp_cnt[0] + rsp_cnt[1], 32'd2);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
         if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
         cycle();
      end
      run_idle(100);
      for (int i = 0; i < DEPTH; i++) chk32("final_mem_word", envmem[i], refmem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
